// File: rtl/clk_div_meter.sv
// rtl/clk_div_meter.sv - measures period, high time and lock of an asynchronous divided clock
// Optional watchdog enabled by defining MEAS_TIMEOUT_EN.
module clk_div_meter #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_div_clk,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_lock,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam int               MW        = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_TRACK} state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, high_q;
  logic [MW-1:0]    match_q, match_d;
  logic             valid_q, lock_q;
  logic             rise, capture, per_sat, is_match;

  always_comb begin
    rise     = s2_q & ~s3_q;
    capture  = rise & (state_q != S_IDLE);
    per_sat  = (per_cnt_q == CNT_MAX);
    // A saturated count is not a real period, so it can never extend a lock.
    is_match = (state_q == S_TRACK) && !per_sat && (per_cnt_q == period_q);
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise) begin
      per_cnt_d = CNT_ONE;
      hi_cnt_d  = CNT_ONE;
    end else begin
      if (!per_sat) per_cnt_d = per_cnt_q + CNT_ONE;
      if (s2_q && (hi_cnt_q != CNT_MAX)) hi_cnt_d = hi_cnt_q + CNT_ONE;
    end
    match_d = MATCH_ONE;
    if (is_match) match_d = (match_q == MATCH_MAX) ? match_q : match_q + MATCH_ONE;
  end

`ifdef MEAS_TIMEOUT_EN
  localparam int            WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;
`else
  localparam int timeout_unused = TIMEOUT;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      match_q   <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
`ifdef MEAS_TIMEOUT_EN
      wd_q      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      s1_q      <= i_div_clk;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      valid_q   <= capture;
      if (capture) begin
        period_q <= per_cnt_q;
        high_q   <= hi_cnt_q;
        match_q  <= match_d;
        lock_q   <= (match_d == MATCH_MAX);
      end
      case (state_q)
        S_IDLE:  if (rise) state_q <= S_ARM;
        S_ARM:   if (rise) state_q <= S_TRACK;
        default: state_q <= S_TRACK;
      endcase
`ifdef MEAS_TIMEOUT_EN
      if (rise) begin
        wd_q      <= '0;
        timeout_q <= 1'b0;
      end else begin
        if (wd_q != WD_MAX) wd_q <= wd_q + WD_W'(1);
        // Fires once on reaching the limit; the counter then parks at WD_MAX.
        if (wd_q == WD_TRIP) begin
          timeout_q <= 1'b1;
          lock_q    <= 1'b0;
          match_q   <= '0;
          state_q   <= S_IDLE;
        end
      end
`endif
    end
  end

  assign o_period = period_q;
  assign o_high   = high_q;
  assign o_valid  = valid_q;
  assign o_lock   = lock_q;
`ifdef MEAS_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_meter.sv
// tb/tb_clk_div_meter.sv - directed self-checking bench for clk_div_meter
// Watchdog steps are built only when MEAS_TIMEOUT_EN is defined.
module tb_clk_div_meter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic div = 1'b0;

  logic [15:0] per_o, hi_o;
  logic        val_o, lock_o, to_o;
  logic [3:0]  per4_o, hi4_o;
  logic        val4_o, lock4_o, to4_o;

  always #5 clk = ~clk;

  clk_div_meter #(.CNT_W(16), .LOCK_CNT(4), .TIMEOUT(50)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_div_clk(div),
    .o_period(per_o), .o_high(hi_o), .o_valid(val_o), .o_lock(lock_o), .o_timeout(to_o)
  );

  clk_div_meter #(.CNT_W(4), .LOCK_CNT(4), .TIMEOUT(50)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_div_clk(div),
    .o_period(per4_o), .o_high(hi4_o), .o_valid(val4_o), .o_lock(lock4_o), .o_timeout(to4_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cap_n = 0, b_n = 0;
  int a_per[256], a_hi[256], a_lock[256], a_cyc[256];
  int b_per[256], b_hi[256], b_lock[256];
  int dbl = 0, dbl4 = 0;
  logic prev_v = 1'b0, prev_v4 = 1'b0;
  int base, bbase, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sample both DUTs at the falling edge, then drive the next input level.
  task automatic tick(input logic v);
    @(negedge clk);
    cyc++;
    if (val_o === 1'b1) begin
      if (cap_n < 256) begin
        a_per[cap_n] = int'(per_o); a_hi[cap_n] = int'(hi_o);
        a_lock[cap_n] = int'(lock_o); a_cyc[cap_n] = cyc;
      end
      cap_n++;
    end
    if (val4_o === 1'b1) begin
      if (b_n < 256) begin
        b_per[b_n] = int'(per4_o); b_hi[b_n] = int'(hi4_o); b_lock[b_n] = int'(lock4_o);
      end
      b_n++;
    end
    if (val_o && prev_v) dbl++;
    if (val4_o && prev_v4) dbl4++;
    prev_v = val_o;
    prev_v4 = val4_o;
    div = v;
  endtask

  task automatic period(input int h, input int l);
    repeat (h) tick(1'b1);
    repeat (l) tick(1'b0);
  endtask

  initial begin
    // 1: reset held with input toggling
    tick(1'b1); tick(1'b0); tick(1'b1);
    chk("rst_no_valid", cap_n, 0);
    chk("rst_period", per_o, 0);
    chk("rst_high", hi_o, 0);
    chk("rst_lock", lock_o, 0);
    chk("rst_timeout", to_o, 0);
    tick(1'b0);
    rst_n = 1'b1;
    repeat (3) tick(1'b0);

    // 2: high 3 / low 4
    base = cap_n;
    repeat (7) period(3, 4);
    chk("p7_count", cap_n - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk("p7_period", a_per[base+i], 7);
      chk("p7_high", a_hi[base+i], 3);
      chk("p7_lock", a_lock[base+i], (i >= 3) ? 1 : 0);
    end
    chk("p7_spacing", a_cyc[base+1] - a_cyc[base], 7);
    chk("p7_spacing2", a_cyc[base+5] - a_cyc[base+4], 7);

    // 3: one period of 9 breaks lock, relock on the 4th period-9 capture
    base = cap_n;
    repeat (5) period(4, 5);
    chk("p9_count", cap_n - base, 5);
    chk("p9_prev7", a_per[base], 7);
    chk("p9_prev7_lock", a_lock[base], 1);
    chk("p9_first_period", a_per[base+1], 9);
    chk("p9_first_high", a_hi[base+1], 4);
    chk("p9_first_lock", a_lock[base+1], 0);
    chk("p9_lock2", a_lock[base+2], 0);
    chk("p9_lock3", a_lock[base+3], 0);
    chk("p9_lock4", a_lock[base+4], 1);
    chk("p9_period4", a_per[base+4], 9);

    // 4: period 20 on a 4-bit counter saturates at 15 and never locks
    base = cap_n;
    bbase = b_n;
    repeat (5) period(10, 10);
    chk("sat_count", b_n - bbase, 5);
    for (int i = 1; i < 5; i++) begin
      chk("sat_period", b_per[bbase+i], 15);
      chk("sat_high", b_hi[bbase+i], 10);
      chk("sat_lock", b_lock[bbase+i], 0);
    end
    chk("p20_period", a_per[base+1], 20);
    chk("p20_lock", a_lock[base+4], 1);

    // 6: asynchronous reset mid-period while locked
    tick(1'b1); tick(1'b1); tick(1'b1);
    chk("pre_rst_lock", lock_o, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_period", per_o, 0);
    chk("arst_high", hi_o, 0);
    chk("arst_lock", lock_o, 0);
    chk("arst_valid", val_o, 0);
    div = 1'b0;
    tick(1'b0); tick(1'b0);
    rst_n = 1'b1;
    base = cap_n;
    repeat (2) tick(1'b0);
    period(3, 4);
    chk("rst_first_rise_no_valid", cap_n - base, 0);
    period(3, 4);
    chk("rst_second_rise_valid", cap_n - base, 1);
    chk("rst_second_period", a_per[base], 7);
    chk("rst_second_high", a_hi[base], 3);

    repeat (5) period(3, 4);
    chk("relock", lock_o, 1);

`ifdef MEAS_TIMEOUT_EN
    // 5: watchdog after the input stops
    n = 0;
    tick(1'b1);
    repeat (2) begin tick(1'b1); n++; end
    while (to_o !== 1'b1 && n < 200) begin tick(1'b0); n++; end
    chk("to_latency", n, 53);
    chk("to_flag", to_o, 1);
    chk("to_lock", lock_o, 0);
    chk("to_period_hold", per_o, 7);
    chk("to_high_hold", hi_o, 3);
    base = cap_n;
    period(3, 4);
    chk("to_clear", to_o, 0);
    chk("to_first_rise_no_valid", cap_n - base, 0);
    period(3, 4);
    chk("to_second_rise_valid", cap_n - base, 1);
    chk("to_restart_period", a_per[base], 7);
`else
    // Without the watchdog a stopped input just holds the outputs.
    tick(1'b0);
    base = cap_n;
    repeat (100) tick(1'b0);
    chk("hold_no_valid", cap_n - base, 0);
    chk("hold_timeout", to_o, 0);
    chk("hold_lock", lock_o, 1);
    chk("hold_period", per_o, 7);
`endif

    chk("valid_single_cycle", dbl, 0);
    chk("valid4_single_cycle", dbl4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
